// File: rtl/prog_load_run_check.sv
// Self-test sequencer: streams program words into byte-wide IMEM, runs the core
// for a fixed budget, then checks register-file contents against an expected stream.
module prog_load_run_check #(
  parameter int unsigned INSTR_W    = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned RF_AW      = 5,
  parameter int unsigned RUN_CYCLES = 20,
  parameter int unsigned CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  output logic               im_we,
  output logic [IMEM_AW-1:0] im_addr,
  output logic [7:0]         im_wdata,
  output logic               core_rst,
  output logic [RF_AW-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]  rf_rdata,
  input  logic               chk_valid,
  output logic               chk_ready,
  input  logic [RF_AW-1:0]   chk_reg,
  input  logic [DATA_W-1:0]  chk_val,
  input  logic               chk_last,
  output logic [CNT_W-1:0]   pass_cnt,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic               overflow,
  output logic               busy,
  output logic               done
);

  localparam int unsigned BYTES = INSTR_W / 8;
  localparam int unsigned BC_W  = $clog2(BYTES + 1);
  localparam int unsigned RC_W  = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_ISSUE, S_CMP, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [INSTR_W-1:0]   r_shift;
  logic [BC_W-1:0]      r_bcnt;
  logic                 r_last_word;
  logic [IMEM_AW:0]     r_addr;
  logic [RC_W-1:0]      r_run_cnt;
  logic [DATA_W-1:0]    r_exp;
  logic                 r_exp_last;
  logic [RF_AW-1:0]     r_raddr;
  logic [CNT_W-1:0]     r_pass, r_fail;
  logic                 r_ovf;

  logic w_start, w_byte, w_wrap, w_ld_acc, w_chk_acc, w_match;

  assign w_start   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_byte    = (r_state == S_LOAD) && (r_bcnt != '0);
  // Extra address bit marks that IMEM has been filled; the pointer parks there.
  assign w_wrap    = r_addr[IMEM_AW];
  assign w_ld_acc  = ld_ready && ld_valid;
  assign w_chk_acc = chk_ready && chk_valid;
  assign w_match   = (rf_rdata == r_exp);

  assign im_we    = w_byte && !w_wrap;
  assign im_addr  = r_addr[IMEM_AW-1:0];
  assign im_wdata = r_shift[INSTR_W-1 -: 8];
  assign rf_raddr = r_raddr;
  assign pass_cnt = r_pass;
  assign fail_cnt = r_fail;
  assign overflow = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    ld_ready  = 1'b0;
    chk_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    core_rst  = 1'b1;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        busy     = 1'b1;
        ld_ready = (r_bcnt == '0);
        if (w_byte && r_bcnt == BC_W'(1) && r_last_word) w_next = S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        core_rst = 1'b0;
        if (r_run_cnt == RC_W'(RUN_CYCLES - 1)) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        chk_ready = 1'b1;
        if (chk_valid) w_next = S_CMP;
      end
      S_CMP: begin
        busy   = 1'b1;
        w_next = r_exp_last ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_next = S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_bcnt      <= '0;
      r_last_word <= 1'b0;
      r_addr      <= '0;
      r_run_cnt   <= '0;
      r_exp       <= '0;
      r_exp_last  <= 1'b0;
      r_raddr     <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= '0;
        r_pass <= '0;
        r_fail <= '0;
        r_ovf  <= 1'b0;
        r_bcnt <= '0;
      end

      if (w_ld_acc) begin
        r_shift     <= ld_data;
        r_bcnt      <= BC_W'(BYTES);
        r_last_word <= ld_last;
      end else if (w_byte) begin
        r_shift <= r_shift << 8;
        r_bcnt  <= r_bcnt - BC_W'(1);
        if (w_wrap) r_ovf  <= 1'b1;
        else        r_addr <= r_addr + (IMEM_AW+1)'(1);
      end

      if (r_state == S_RUN) r_run_cnt <= r_run_cnt + RC_W'(1);
      else                  r_run_cnt <= '0;

      if (w_chk_acc) begin
        r_raddr    <= chk_reg;
        r_exp      <= chk_val;
        r_exp_last <= chk_last;
      end

      if (r_state == S_CMP) begin
        if (w_match) begin
          if (r_pass != '1) r_pass <= r_pass + CNT_W'(1);
        end else begin
          if (r_fail != '1) r_fail <= r_fail + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_load_run_check.sv
// Scoreboard bench: two sequencer instances (full-size and small IMEM/2-bit counters)
// share one stimulus stream; a negedge monitor pops expected writes, run lengths and results.
module tb_prog_load_run_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        chk_valid;
  logic [4:0]  chk_reg;
  logic [31:0] chk_val;
  logic        chk_last;

  logic        ld_ready_a, im_we_a, core_rst_a, chk_ready_a, ovf_a, busy_a, done_a;
  logic [7:0]  im_addr_a, im_wdata_a, pass_a, fail_a;
  logic [4:0]  rf_raddr_a;
  logic [31:0] rf_rdata_a;

  logic        ld_ready_b, im_we_b, core_rst_b, chk_ready_b, ovf_b, busy_b, done_b;
  logic [3:0]  im_addr_b;
  logic [7:0]  im_wdata_b;
  logic [1:0]  pass_b, fail_b;
  logic [4:0]  rf_raddr_b;
  logic [31:0] rf_rdata_b;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] r);
    case (r)
      5'd0:    rf_val = 32'h0000_0000;
      5'd1:    rf_val = 32'h0000_0007;
      5'd2:    rf_val = 32'h0000_0005;
      5'd3:    rf_val = 32'h0000_000A;
      5'd4:    rf_val = 32'h0000_0100;
      5'd5:    rf_val = 32'hFFFF_FFFF;
      default: rf_val = 32'h0000_0000;
    endcase
  endfunction

  assign rf_rdata_a = rf_val(rf_raddr_a);
  assign rf_rdata_b = rf_val(rf_raddr_b);

  prog_load_run_check #(.INSTR_W(32), .DATA_W(32), .IMEM_AW(8), .RF_AW(5),
                        .RUN_CYCLES(20), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_data(ld_data), .ld_last(ld_last),
    .im_we(im_we_a), .im_addr(im_addr_a), .im_wdata(im_wdata_a),
    .core_rst(core_rst_a), .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
    .chk_valid(chk_valid), .chk_ready(chk_ready_a), .chk_reg(chk_reg),
    .chk_val(chk_val), .chk_last(chk_last),
    .pass_cnt(pass_a), .fail_cnt(fail_a), .overflow(ovf_a), .busy(busy_a), .done(done_a)
  );

  prog_load_run_check #(.INSTR_W(32), .DATA_W(32), .IMEM_AW(4), .RF_AW(5),
                        .RUN_CYCLES(20), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start),
    .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_data(ld_data), .ld_last(ld_last),
    .im_we(im_we_b), .im_addr(im_addr_b), .im_wdata(im_wdata_b),
    .core_rst(core_rst_b), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .chk_valid(chk_valid), .chk_ready(chk_ready_b), .chk_reg(chk_reg),
    .chk_val(chk_val), .chk_last(chk_last),
    .pass_cnt(pass_b), .fail_cnt(fail_b), .overflow(ovf_b), .busy(busy_b), .done(done_b)
  );

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  typedef struct { int unsigned pa, fa, oa, pb, fb, ob; } res_t;

  wr_t         q_wr_a[$];
  wr_t         q_wr_b[$];
  int unsigned q_run[$];
  res_t        q_res[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_at(input int unsigned a);
    byte_at = 8'((a * 7 + 3) & 255);
  endfunction

  function automatic logic [31:0] gen_word(input int unsigned k);
    logic [31:0] w;
    for (int unsigned i = 0; i < 4; i++) w[31 - 8*i -: 8] = byte_at(4*k + i);
    gen_word = w;
  endfunction

  task automatic push_gen_writes(input int unsigned nbytes);
    for (int unsigned a = 0; a < nbytes; a++) begin
      q_wr_a.push_back('{a, int'(byte_at(a))});
      if (a < 16) q_wr_b.push_back('{a, int'(byte_at(a))});
    end
  endtask

  task automatic push_word1_writes();
    q_wr_a.push_back('{0, 'h4C}); q_wr_a.push_back('{1, 'h80});
    q_wr_a.push_back('{2, 'h00}); q_wr_a.push_back('{3, 'h05});
    q_wr_b.push_back('{0, 'h4C}); q_wr_b.push_back('{1, 'h80});
    q_wr_b.push_back('{2, 'h00}); q_wr_b.push_back('{3, 'h05});
  endtask

  // Pulse start with the first word already valid; nothing may be accepted that cycle.
  task automatic do_start(input logic [31:0] w, input logic last);
    @(posedge clk); #1;
    start = 1'b1; ld_valid = 1'b1; ld_data = w; ld_last = last;
    check("ld_ready_at_start", ld_ready_a, 0);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int t = 0;
    ld_valid = 1'b1; ld_data = w; ld_last = last;
    while (!ld_ready_a && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("timeout_ld_ready", 0, 1);
    @(posedge clk); #1;
    if (last) ld_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [4:0] r, input logic [31:0] v, input logic last);
    int t = 0;
    chk_valid = 1'b1; chk_reg = r; chk_val = v; chk_last = last;
    while (!chk_ready_a && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) check("timeout_chk_ready", 0, 1);
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_a && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) check("timeout_done", 0, 1);
  endtask

  task automatic seq_basic();
    push_word1_writes();
    q_run.push_back(20);
    q_res.push_back('{1, 1, 0, 1, 1, 0});
    do_start(32'h4C80_0005, 1'b1);
    send_word(32'h4C80_0005, 1'b1);
    send_chk(5'd2, 32'd5, 1'b0);
    send_chk(5'd3, 32'd9, 1'b1);
    wait_done();
  endtask

  // Monitor state
  int unsigned cyc = 0;
  int unsigned prev_acc = 0;
  bit          have_prev = 0;
  int unsigned low_a = 0, low_b = 0;
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    wr_t  w;
    res_t r;
    int unsigned exp_run;
    cyc++;
    if (rst) begin
      low_a = 0; low_b = 0; prev_done = 1'b0; have_prev = 0;
    end else begin
      if (im_we_a) begin
        check("ld_ready_during_write", ld_ready_a, 0);
        if (q_wr_a.size() == 0) check("unexpected_write_a", 1, 0);
        else begin
          w = q_wr_a.pop_front();
          check("im_addr_a", im_addr_a, w.addr);
          check("im_wdata_a", im_wdata_a, w.data);
        end
      end
      if (im_we_b) begin
        if (q_wr_b.size() == 0) check("unexpected_write_b", 1, 0);
        else begin
          w = q_wr_b.pop_front();
          check("im_addr_b", im_addr_b, w.addr);
          check("im_wdata_b", im_wdata_b, w.data);
        end
      end

      if (start) have_prev = 0;
      if (ld_valid && ld_ready_a) begin
        if (have_prev) check("accept_spacing", cyc - prev_acc, 5);
        prev_acc  = cyc;
        have_prev = 1;
      end

      if (!core_rst_a) low_a++;
      if (!core_rst_b) low_b++;
      if (core_rst_a && low_a > 0) begin
        if (q_run.size() == 0) check("unexpected_run", 1, 0);
        else begin
          exp_run = q_run.pop_front();
          check("run_len_a", low_a, exp_run);
          check("run_len_b", low_b, exp_run);
          check("busy_in_check", busy_a, 1);
        end
        low_a = 0; low_b = 0;
      end

      if (done_a && !prev_done) begin
        if (q_res.size() == 0) check("unexpected_done", 1, 0);
        else begin
          r = q_res.pop_front();
          check("pass_a", pass_a, r.pa);
          check("fail_a", fail_a, r.fa);
          check("ovf_a", ovf_a, r.oa);
          check("pass_b", pass_b, r.pb);
          check("fail_b", fail_b, r.fb);
          check("ovf_b", ovf_b, r.ob);
          check("done_b", done_b, 1);
          check("busy_at_done", busy_a, 0);
          check("core_rst_at_done", core_rst_a, 1);
        end
      end
      prev_done = done_a;
    end
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    chk_valid = 1'b0; chk_reg = '0; chk_val = '0; chk_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_rst", core_rst_a, 1);
    check("rst_ld_ready", ld_ready_a, 0);
    check("rst_im_we", im_we_a, 0);
    check("rst_im_addr", im_addr_a, 0);
    check("rst_im_wdata", im_wdata_a, 0);
    check("rst_chk_ready", chk_ready_a, 0);
    check("rst_counts", {pass_a, fail_a}, 0);
    check("rst_flags", {ovf_a, busy_a, done_a}, 0);
    check("rst_b_flags", {core_rst_b, ovf_b, busy_b, done_b}, 4'b1000);
    #2 rst = 1'b0;

    // Single word, one pass and one mismatch
    seq_basic();

    // Nine back-to-back words; the small instance overflows after 16 bytes
    push_gen_writes(36);
    q_run.push_back(20);
    q_res.push_back('{3, 0, 0, 3, 0, 1});
    do_start(gen_word(0), 1'b0);
    for (int unsigned k = 0; k < 9; k++) send_word(gen_word(k), k == 8);
    send_chk(5'd0, 32'd0, 1'b0);
    send_chk(5'd2, 32'd5, 1'b0);
    send_chk(5'd3, 32'd10, 1'b1);
    wait_done();

    // Five words, five mismatches; 2-bit fail counter saturates at 3
    push_gen_writes(20);
    q_run.push_back(20);
    q_res.push_back('{0, 5, 0, 0, 3, 1});
    do_start(gen_word(0), 1'b0);
    for (int unsigned k = 0; k < 5; k++) send_word(gen_word(k), k == 4);
    send_chk(5'd1, 32'd8, 1'b0);
    send_chk(5'd2, 32'd4, 1'b0);
    send_chk(5'd3, 32'd11, 1'b0);
    send_chk(5'd4, 32'd0, 1'b0);
    send_chk(5'd5, 32'd0, 1'b1);
    wait_done();

    // Abort mid-RUN with asynchronous reset
    push_word1_writes();
    do_start(32'h4C80_0005, 1'b1);
    send_word(32'h4C80_0005, 1'b1);
    t = 0;
    while (core_rst_a && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check("timeout_run_entry", 0, 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_core_rst_a", core_rst_a, 1);
    check("abort_core_rst_b", core_rst_b, 1);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_im_we", im_we_a, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Sequencer recovers from IDLE after the abort
    seq_basic();

    repeat (5) @(posedge clk);
    #1;
    check("pending_writes_a", q_wr_a.size(), 0);
    check("pending_writes_b", q_wr_b.size(), 0);
    check("pending_runs", q_run.size(), 0);
    check("pending_results", q_res.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
